// File: rtl/sgx_reset_pkg.sv
// sgx_reset_pkg: shared FSM state type and cause bit positions for sgx_reset_request.
package sgx_reset_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;
  localparam int CAUSE_LOCK   = 0;
  localparam int CAUSE_BUTTON = 1;
  localparam int CAUSE_SW     = 2;
  localparam int CAUSE_WDOG   = 3;
endpackage

// File: rtl/sgx_sync_bit.sv
// sgx_sync_bit: single-bit multi-flop synchronizer with a selectable reset value.
module sgx_sync_bit #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic areset_n,
  input  logic d,
  output logic q
);
  logic [DEPTH-1:0] sr;
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) sr <= {DEPTH{RST_VAL}};
    else sr <= (sr << 1) | DEPTH'(d);
  end
  assign q = sr[DEPTH-1];
endmodule

// File: rtl/sgx_reset_request.sv
// sgx_reset_request: sequences a system reset request from PLL lock, button, software and watchdog.
// Define SGX_RESET_WDOG_EN to build the watchdog; otherwise wdog_kick is ignored and cause[3] stays 0.
module sgx_reset_request
  import sgx_reset_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE_BITS = 8,
  parameter int HOLD_BITS     = 8,
  parameter int WDOG_BITS     = 16
) (
  input  logic       clock,
  input  logic       areset_n,
  input  logic       pll_locked,
  input  logic       button_n,
  input  logic       sw_req,
  output logic       sw_ack,
  input  logic       wdog_kick,
  output logic       sys_reset,
  output logic [3:0] cause
);
  state_t state, state_nx;
  logic lock_s, btn_s, pressed, press, wdog_exp, run;
  logic [3:0] trig;
  logic [HOLD_BITS-1:0] hold_cnt;
  logic [DEBOUNCE_BITS-1:0] deb_cnt;

  sgx_sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
    .clock(clock), .areset_n(areset_n), .d(pll_locked), .q(lock_s)
  );
  sgx_sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_btn_sync (
    .clock(clock), .areset_n(areset_n), .d(button_n), .q(btn_s)
  );

  assign run = state == RUN;
  // press is a single pulse on the first saturated cycle; pressed blocks refire until release
  assign press = !btn_s && &deb_cnt && !pressed;

`ifdef SGX_RESET_WDOG_EN
  logic [WDOG_BITS-1:0] wdog_cnt;
  assign wdog_exp = &wdog_cnt && !wdog_kick;
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) wdog_cnt <= '0;
    else wdog_cnt <= (!run || wdog_kick) ? '0 : wdog_cnt + WDOG_BITS'(1);
  end
`else
  logic [WDOG_BITS-1:0] unused_wdog;
  assign unused_wdog = {WDOG_BITS{wdog_kick}};
  assign wdog_exp = 1'b0;
`endif

  always_comb begin
    trig = '0;
    trig[CAUSE_LOCK]   = !lock_s;
    trig[CAUSE_BUTTON] = press;
    trig[CAUSE_SW]     = sw_req;
    trig[CAUSE_WDOG]   = wdog_exp;
  end

  assign state_nx = (state == WAIT_LOCK) ? (lock_s ? HOLD : WAIT_LOCK) :
                    (state == HOLD)      ? (!lock_s ? WAIT_LOCK : &hold_cnt ? RUN : HOLD) :
                    (run && trig == 4'b0000) ? RUN : WAIT_LOCK;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state     <= WAIT_LOCK;
      hold_cnt  <= '0;
      deb_cnt   <= '0;
      pressed   <= 1'b0;
      sys_reset <= 1'b1;
      sw_ack    <= 1'b0;
      cause     <= 4'b0000;
    end else begin
      state     <= state_nx;
      hold_cnt  <= (state == HOLD) ? hold_cnt + HOLD_BITS'(1) : '0;
      deb_cnt   <= btn_s ? '0 : &deb_cnt ? deb_cnt : deb_cnt + DEBOUNCE_BITS'(1);
      pressed   <= !btn_s && &deb_cnt;
      sys_reset <= state_nx != RUN;
      sw_ack    <= run && sw_req;
      if (run && |trig) cause <= trig;
    end
  end
endmodule
